// File: rtl/aes_round_key_cache.sv
// Round-key cache: captures NR+1 expanded round keys in order and serves them by index with 1-cycle latency.
// Optional per-byte parity protection of stored keys is enabled by defining RKC_PARITY_EN.
module aes_round_key_cache #(
   parameter int NR       = 14,
   parameter int RK_WIDTH = 128,
   parameter int IDX_W    = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush_i,
   input  logic                rk_valid_i,
   output logic                rk_ready_o,
   input  logic [RK_WIDTH-1:0] rk_data_i,
   input  logic                rd_req_i,
   input  logic [IDX_W-1:0]    rd_round_i,
   input  logic                rd_inv_i,
   output logic                rd_valid_o,
   output logic [RK_WIDTH-1:0] rd_key_o,
   output logic                rd_err_o,
   output logic [IDX_W-1:0]    fill_cnt_o,
   output logic                full_o,
   output logic                parity_err_o
);

   localparam logic [IDX_W-1:0] DEPTH = IDX_W'(NR + 1);
   localparam logic [IDX_W:0]   NR_X  = (IDX_W + 1)'(NR);

   typedef enum logic [1:0] {EMPTY, FILL, FULL} state_t;

   state_t              state, state_next;
   logic [IDX_W-1:0]    fill_cnt, cnt_next;
   logic                ready, ready_next;
   logic                wr;

   logic [IDX_W:0]      round_x, p;
   logic                bypass, rd_ok;
   logic [IDX_W-1:0]    rd_idx;
   logic [RK_WIDTH-1:0] rd_data;

   logic                rd_valid, rd_err;
   logic [RK_WIDTH-1:0] rd_key;

   logic [RK_WIDTH-1:0] mem [0:NR];

   always_comb begin
      state_next = state;
      cnt_next   = fill_cnt;
      wr         = rk_valid_i && ready && !flush_i;
      if (flush_i) begin
         state_next = EMPTY;
         cnt_next   = '0;
      end else if (wr) begin
         cnt_next   = fill_cnt + 1'b1;
         state_next = (cnt_next == DEPTH) ? FULL : FILL;
      end
      ready_next = (state_next != FULL);
   end

   // Index math is one bit wider than the round index so NR - round never wraps into a valid slot.
   always_comb begin
      round_x = {1'b0, rd_round_i};
      p       = rd_inv_i ? (NR_X - round_x) : round_x;
      bypass  = wr && (p == {1'b0, fill_cnt});
      rd_ok   = !flush_i && (round_x <= NR_X) && ((p < {1'b0, fill_cnt}) || bypass);
      rd_idx  = rd_ok ? p[IDX_W-1:0] : '0;
      rd_data = bypass ? rk_data_i : mem[rd_idx];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= EMPTY;
         fill_cnt <= '0;
         ready    <= 1'b1;
         rd_valid <= 1'b0;
         rd_err   <= 1'b0;
         rd_key   <= '0;
      end else begin
         state    <= state_next;
         fill_cnt <= cnt_next;
         ready    <= ready_next;
         rd_valid <= rd_req_i && rd_ok;
         rd_err   <= rd_req_i && !rd_ok;
         if (rd_req_i && rd_ok) begin
            rd_key <= rd_data;
         end
      end
   end

   // Storage is never cleared; validity is tracked solely by fill_cnt.
   always_ff @(posedge clk) begin
      if (rst_n && wr) begin
         mem[fill_cnt] <= rk_data_i;
      end
   end

`ifdef RKC_PARITY_EN
   localparam int NB = RK_WIDTH / 8;

   function automatic logic [NB-1:0] byte_par(input logic [RK_WIDTH-1:0] d);
      logic [NB-1:0] r;
      r = '0;
      for (int unsigned b = 0; b < NB; b++) begin
         r[b] = ^d[8*b +: 8];
      end
      return r;
   endfunction

   logic [NB-1:0] par_mem [0:NR];
   logic [NB-1:0] par_stored;
   logic          par_mismatch;
   logic          par_err;

   always_comb begin
      par_stored   = bypass ? byte_par(rk_data_i) : par_mem[rd_idx];
      par_mismatch = (byte_par(rd_data) != par_stored);
   end

   always_ff @(posedge clk) begin
      if (rst_n && wr) begin
         par_mem[fill_cnt] <= byte_par(rk_data_i);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         par_err <= 1'b0;
      end else begin
         par_err <= rd_req_i && rd_ok && par_mismatch;
      end
   end

   assign parity_err_o = par_err;
`else
   assign parity_err_o = 1'b0;
`endif

   assign rk_ready_o = ready;
   assign fill_cnt_o = fill_cnt;
   assign full_o     = (fill_cnt == DEPTH);
   assign rd_valid_o = rd_valid;
   assign rd_err_o   = rd_err;
   assign rd_key_o   = rd_key;

endmodule

// File: doc/aes_round_key_cache.md
# aes_round_key_cache

Round-key cache between the AES-256 key expansion stage and the AES round datapath. It captures the 15 × 128-bit round keys (round 0..14) that key expansion produces in order. It then serves any round key by index with fixed 1-cycle latency, in forward (encrypt) or reversed (decrypt) order. Key expansion therefore runs once per key rather than once per block, and CTR-mode block throughput does not depend on key-schedule latency.

## Interface
- NR, 14, number of AES rounds; the cache holds NR+1 entries.
- RK_WIDTH, 128, round-key width in bits.
- IDX_W, 4, width of round index and fill count.
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- flush_i  input  1  invalidates all entries (new key loaded).
- rk_valid_i  input  1  round key from key expansion is valid.
- rk_ready_o  output  1  cache can accept a round key.
- rk_data_i  input  RK_WIDTH  round key; the i-th accepted key is round i.
- rd_req_i  input  1  read request.
- rd_round_i  input  IDX_W  logical round index, 0..NR.
- rd_inv_i  input  1  1 = inverse order; physical entry = NR − rd_round_i.
- rd_valid_o  output  1  one-cycle pulse: rd_key_o carries requested key.
- rd_key_o  output  RK_WIDTH  read data; holds last value between reads.
- rd_err_o  output  1  one-cycle pulse: request rejected.
- fill_cnt_o  output  IDX_W  number of valid entries, 0..NR+1.
- full_o  output  1  all NR+1 entries valid.
- parity_err_o  output  1  one-cycle pulse on stored-parity mismatch (see Configuration).

## Operation
- States:
  - EMPTY: fill_cnt = 0, rk_ready_o = 1.
  - FILL: 0 < fill_cnt < NR+1, rk_ready_o = 1.
  - FULL: fill_cnt = NR+1, rk_ready_o = 0.
- Transitions:
  - EMPTY→FILL on the first accepted write.
  - FILL→FULL on the write that makes fill_cnt = NR+1.
  - Any state→EMPTY on flush_i.
- Write handshake: a transfer occurs when rk_valid_i && rk_ready_o. rk_data_i is stored at entry fill_cnt, and fill_cnt increments by 1.
- Writes in FULL are impossible, because rk_ready_o = 0. rk_valid_i asserted in FULL is ignored with no side effects.
- Physical index p = rd_inv_i ? NR − rd_round_i : rd_round_i. It is computed in IDX_W+1 bits, so no wrap-around occurs.
- A read is rejected (rd_err_o = 1, rd_valid_o = 0, rd_key_o unchanged) in any of these cases:
  - rd_round_i > NR.
  - p ≥ fill_cnt and p is not the entry being written this cycle.
  - flush_i is asserted in the same cycle.
- Write-through bypass: if a read hits p == fill_cnt in the same cycle that a write is accepted, rk_data_i is returned. Forward encryption can therefore start while key expansion is still running.
- A read during FILL at p < fill_cnt is legal.
- flush_i has priority over a simultaneous write. The write is dropped, and fill_cnt = 0 next cycle.
- Storage RAM is not cleared by reset or flush. Validity is governed only by fill_cnt.
- fill_cnt_o never exceeds NR+1. full_o = (fill_cnt == NR+1).

## Timing
- Reset (rst_n = 0 at the edge) sets:
  - state = EMPTY, fill_cnt_o = 0, full_o = 0, rk_ready_o = 1.
  - rd_valid_o = 0, rd_err_o = 0, parity_err_o = 0, rd_key_o = 0.
- Reset asserted mid-fill or mid-read discards that operation. No pulse appears after reset.
- Write-to-read: an entry written at edge N is readable by a request sampled at edge N+1, or at edge N through the bypass.
- Read latency is 1 cycle. A request sampled at edge N gives rd_valid_o/rd_err_o high during the cycle after edge N. One request per cycle is allowed, fully pipelined.
- rk_ready_o is a registered function of state. It falls in the cycle after the 15th transfer.
- fill_cnt_o and full_o update at the same edge as the write or flush.

## Configuration
- Macro RKC_PARITY_EN.
- Defined:
  - Each entry stores 16 extra bits: even parity per byte of the round key.
  - Every successful read recomputes parity.
  - Any byte mismatch pulses parity_err_o together with rd_valid_o. The data is still returned.
- Undefined:
  - No parity storage or logic.
  - parity_err_o is tied to 0.
  - All other behaviour is identical.

## Test plan
- Reset, then stream 15 keys (key i = {16{8'(i)}}) with rk_valid_i held high → rk_ready_o = 0 and full_o = 1 after the 15th edge, and fill_cnt_o = 15. A 16th rk_valid_i does not change fill_cnt_o.
- In FULL, read rounds 0..14 back-to-back with rd_inv_i = 0, then with rd_inv_i = 1 → rd_valid_o high for 15 consecutive cycles. Keys returned are 0..14 in forward order and 14..0 in inverse order, each 1 cycle after its request.
- Error and bypass cases:
  - After 3 writes: read rd_round_i = 5 → rd_err_o pulse, rd_key_o unchanged.
  - Read 3 in the same cycle as the 4th write → rd_valid_o with key 3 (bypass).
  - Read rd_round_i = 15 → rd_err_o.
- flush_i asserted together with a write and a read at fill_cnt = 7 → next cycle fill_cnt_o = 0, rk_ready_o = 1, rd_err_o = 1. The following refill starts at entry 0.
- rst_n low for 1 cycle mid-fill (fill_cnt = 9) → all outputs at reset values. A subsequent read of round 0 returns rd_err_o.
- With RKC_PARITY_EN defined, force one bit of stored entry 6 and read round 6 → rd_valid_o = 1 and parity_err_o = 1 in the same cycle. Reads of other entries give parity_err_o = 0.
